// File: rtl/nibble_seq_gen_pkg.sv
// ============================================================================
// Module  : nibble_seq_gen_pkg
// Brief   : Shared encodings, sequence lengths and value helpers for the
//           nibble stimulus sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_seq_gen_pkg;

    // Sequence select encodings
    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DN   = 2'b01;
    localparam logic [1:0] MODE_WALK = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Number of values emitted per sequence, first value included
    localparam int SEQ_LEN_COUNT = 16;
    localparam int SEQ_LEN_WALK  = 4;
    localparam int SEQ_LEN_HOLD  = 1;

    // Wide enough to hold SEQ_LEN_COUNT itself
    localparam int STEP_BITS = 5;

    function automatic logic [STEP_BITS-1:0] seq_len(input logic [1:0] mode);
        logic [STEP_BITS-1:0] len;
        case (mode)
            MODE_UP,
            MODE_DN:   len = STEP_BITS'(SEQ_LEN_COUNT);
            MODE_WALK: len = STEP_BITS'(SEQ_LEN_WALK);
            default:   len = STEP_BITS'(SEQ_LEN_HOLD);
        endcase
        return len;
    endfunction

    function automatic logic [3:0] first_value(input logic [1:0] mode,
                                               input logic [3:0] load_val);
        logic [3:0] val;
        if (mode == MODE_WALK) begin
            val = 4'b0001;
        end else begin
            val = load_val;
        end
        return val;
    endfunction

    function automatic logic [3:0] next_value(input logic [1:0] mode,
                                              input logic [3:0] cur);
        logic [3:0] val;
        case (mode)
            MODE_UP:   val = cur + 4'd1;
            MODE_DN:   val = cur - 4'd1;
            MODE_WALK: val = {cur[2:0], cur[3]};
            default:   val = cur;
        endcase
        return val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_seq_gen_dwell_timer.sv
// ============================================================================
// Module  : dwell_timer
// Brief   : Free-running dwell counter with clear/enable; terminal count
//           flags the last cycle of a DWELL-cycle hold period.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dwell_timer #(
    parameter int DWELL   = 10,
    parameter int DW_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [DW_BITS-1:0] c_TERMINAL = DW_BITS'(DWELL - 1);
    localparam logic [DW_BITS-1:0] c_ONE      = DW_BITS'(1);

    logic [DW_BITS-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            // Wrap on terminal count so the next value starts a fresh dwell
            r_count <= o_tc ? '0 : r_count + c_ONE;
        end
    end

    assign o_tc = (r_count == c_TERMINAL);

endmodule

`default_nettype wire

// File: rtl/nibble_seq_gen.sv
// ============================================================================
// Module  : nibble_seq_gen
// Brief   : Registered 4-bit stimulus sequencer with start/stop handshake,
//           per-value STEP strobe and BUSY/DONE status.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_seq_gen
    import nibble_seq_gen_pkg::*;
#(
    parameter int DWELL   = 10,
    parameter int DW_BITS = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       STOP,
    input  logic [1:0] MODE,
    input  logic [3:0] LOAD_VAL,
    output logic [3:0] NIB_OUT,
    output logic       STEP,
    output logic       BUSY,
    output logic       DONE
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_mode;
    logic [1:0]             w_mode_nxt;
    logic [STEP_BITS-1:0]   r_step_cnt;
    logic [STEP_BITS-1:0]   w_step_cnt_nxt;
    logic [3:0]             r_nib;
    logic [3:0]             w_nib_nxt;
    logic                   r_step;
    logic                   w_step_nxt;
    logic                   r_busy;
    logic                   w_busy_nxt;
    logic                   r_done;
    logic                   w_done_nxt;
    logic                   w_timer_clr;
    logic                   w_timer_en;
    logic                   w_tc;

    dwell_timer #(
        .DWELL   (DWELL),
        .DW_BITS (DW_BITS)
    ) u_dwell_timer (
        .clk   (CLK),
        .rst   (RST),
        .i_clr (w_timer_clr),
        .i_en  (w_timer_en),
        .o_tc  (w_tc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_mode     <= MODE_UP;
            r_step_cnt <= '0;
            r_nib      <= 4'h0;
            r_step     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mode     <= w_mode_nxt;
            r_step_cnt <= w_step_cnt_nxt;
            r_nib      <= w_nib_nxt;
            r_step     <= w_step_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_mode_nxt     = r_mode;
        w_step_cnt_nxt = r_step_cnt;
        w_nib_nxt      = r_nib;
        w_step_nxt     = 1'b0;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_timer_clr    = 1'b0;
        w_timer_en     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Timer parked at zero so the first value gets a full dwell
                w_timer_clr = 1'b1;
                if (START) begin
                    w_state_nxt    = ST_RUN;
                    w_mode_nxt     = MODE;
                    w_nib_nxt      = first_value(MODE, LOAD_VAL);
                    w_step_cnt_nxt = STEP_BITS'(1);
                    w_step_nxt     = 1'b1;
                    w_busy_nxt     = 1'b1;
                end
            end

            ST_RUN: begin
                // STOP takes priority over a dwell expiry on the same cycle
                if (STOP) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_timer_clr = 1'b1;
                end else begin
                    w_timer_en = 1'b1;
                    if (w_tc) begin
                        if (r_step_cnt == seq_len(r_mode)) begin
                            w_state_nxt = ST_IDLE;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_nib_nxt      = next_value(r_mode, r_nib);
                            w_step_cnt_nxt = r_step_cnt + STEP_BITS'(1);
                            w_step_nxt     = 1'b1;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign NIB_OUT = r_nib;
    assign STEP    = r_step;
    assign BUSY    = r_busy;
    assign DONE    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_nibble_seq_gen.sv
// ============================================================================
// Module  : tb_nibble_seq_gen
// Brief   : Randomized self-checking bench; two sequencers (DWELL=4, DWELL=1)
//           share stimulus and are compared against an elapsed-time model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_seq_gen;

    typedef struct packed {
        logic       run;
        int         k;
        logic [1:0] mode;
        logic [3:0] load;
        logic [3:0] nib;
        logic       step;
        logic       busy;
        logic       done;
    } mdl_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
    logic [1:0] mode     = 2'b00;
    logic [3:0] load_val = 4'h0;

    logic [3:0] nib4, nib1;
    logic       step4, busy4, done4;
    logic       step1, busy1, done1;

    mdl_t m4 = '0;
    mdl_t m1 = '0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    nibble_seq_gen #(.DWELL(4), .DW_BITS(3)) u_dut4 (
        .CLK(clk), .RST(rst), .START(start), .STOP(stop), .MODE(mode),
        .LOAD_VAL(load_val), .NIB_OUT(nib4), .STEP(step4), .BUSY(busy4), .DONE(done4)
    );

    nibble_seq_gen #(.DWELL(1), .DW_BITS(1)) u_dut1 (
        .CLK(clk), .RST(rst), .START(start), .STOP(stop), .MODE(mode),
        .LOAD_VAL(load_val), .NIB_OUT(nib1), .STEP(step1), .BUSY(busy1), .DONE(done1)
    );

    // Value number idx (0-based) of a sequence, straight from the mode rules
    function automatic logic [3:0] seq_val(logic [1:0] m, logic [3:0] l, int idx);
        case (m)
            2'b00:   return 4'((int'(l) + idx) % 16);
            2'b01:   return 4'(int'(l) - idx);
            2'b10:   return 4'(1 << idx);
            default: return l;
        endcase
    endfunction

    function automatic int seq_count(logic [1:0] m);
        return (m == 2'b10) ? 4 : ((m == 2'b11) ? 1 : 16);
    endfunction

    // k = edges elapsed since the START edge; output is a pure function of k
    function automatic mdl_t mdl_next(mdl_t s, int dw, logic r, logic st, logic sp,
                                      logic [1:0] md, logic [3:0] ld);
        mdl_t n;
        n      = s;
        n.step = 1'b0;
        n.done = 1'b0;
        if (r) begin
            n = '0;
        end else if (s.run) begin
            if (sp) begin
                n.run  = 1'b0;
                n.busy = 1'b0;
            end else begin
                n.k = s.k + 1;
                if (n.k == seq_count(s.mode) * dw) begin
                    n.run  = 1'b0;
                    n.busy = 1'b0;
                    n.done = 1'b1;
                end else begin
                    n.nib  = seq_val(s.mode, s.load, n.k / dw);
                    n.step = (n.k % dw == 0);
                end
            end
        end else if (st) begin
            n.run  = 1'b1;
            n.k    = 0;
            n.mode = md;
            n.load = ld;
            n.nib  = seq_val(md, ld, 0);
            n.step = 1'b1;
            n.busy = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m4 <= mdl_next(m4, 4, rst, start, stop, mode, load_val);
        m1 <= mdl_next(m1, 1, rst, start, stop, mode, load_val);
    end

    task automatic test_reset;
        @(posedge clk); #1;
        n_vec++;
        if ({nib4, step4, busy4, done4} !== 7'b0) begin
            n_err++; $display("FAIL reset_d4 got %b want %b", {nib4, step4, busy4, done4}, 7'b0);
        end
        n_vec++;
        if ({nib1, step1, busy1, done1} !== 7'b0) begin
            n_err++; $display("FAIL reset_d1 got %b want %b", {nib1, step1, busy1, done1}, 7'b0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_count_modes;
        logic [1:0] t_mode  [3] = '{2'd0, 2'd1, 2'd2};
        logic [3:0] t_load  [3] = '{4'hE, 4'h1, 4'h7};
        logic [3:0] t_final [3] = '{4'hD, 4'h2, 4'h8};
        int         t_steps [3] = '{16, 16, 4};
        int         t_done  [3] = '{64, 64, 16};
        int         t_cyc   [3] = '{70, 70, 20};
        for (int s = 0; s < 3; s++) begin
            int steps = 0, busy_c = 0, done_n = 0, done_at = -1;
            for (int c = 0; c < t_cyc[s]; c++) begin
                @(negedge clk);
                start    = (c == 0);
                mode     = (c == 0) ? t_mode[s] : 2'($urandom);
                load_val = (c == 0) ? t_load[s] : 4'($urandom);
                @(posedge clk); #1;
                n_vec++;
                if ({nib4, step4, busy4, done4} !== {m4.nib, m4.step, m4.busy, m4.done}) begin
                    n_err++; $display("FAIL seq%0d_d4 c=%0d got %b want %b", s, c,
                        {nib4, step4, busy4, done4}, {m4.nib, m4.step, m4.busy, m4.done});
                end
                n_vec++;
                if ({nib1, step1, busy1, done1} !== {m1.nib, m1.step, m1.busy, m1.done}) begin
                    n_err++; $display("FAIL seq%0d_d1 c=%0d got %b want %b", s, c,
                        {nib1, step1, busy1, done1}, {m1.nib, m1.step, m1.busy, m1.done});
                end
                steps  += int'(step4);
                busy_c += int'(busy4);
                if (done4) begin
                    done_n++;
                    if (done_at < 0) done_at = c;
                end
            end
            n_vec++;
            if (steps != t_steps[s] || busy_c != t_done[s] || done_n != 1 || done_at != t_done[s]
                || nib4 !== t_final[s]) begin
                n_err++; $display("FAIL seq%0d_summary steps=%0d busy=%0d dones=%0d done_at=%0d nib=%h want %0d/%0d/1/%0d/%h",
                    s, steps, busy_c, done_n, done_at, nib4, t_steps[s], t_done[s], t_done[s], t_final[s]);
            end
        end
    endtask

    task automatic test_stop;
        logic hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            start    = (c == 0);
            mode     = 2'b00;
            load_val = 4'h0;
            stop     = (c != 0) && m4.run && (m4.k == 13);
            hit      = stop;
            @(posedge clk); #1;
            n_vec++;
            if ({nib4, step4, busy4, done4} !== {m4.nib, m4.step, m4.busy, m4.done}) begin
                n_err++; $display("FAIL stop_d4 c=%0d got %b want %b", c,
                    {nib4, step4, busy4, done4}, {m4.nib, m4.step, m4.busy, m4.done});
            end
        end
        n_vec++;
        if (!hit || {nib4, step4, busy4, done4} !== {4'h3, 3'b000}) begin
            n_err++; $display("FAIL stop_hold hit=%b got %b want %b", hit,
                {nib4, step4, busy4, done4}, {4'h3, 3'b000});
        end
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            stop     = 1'b0;
            start    = (c == 0);
            load_val = (c == 0) ? 4'h9 : 4'($urandom);
            @(posedge clk); #1;
            n_vec++;
            if ({nib4, step4, busy4, done4} !== {m4.nib, m4.step, m4.busy, m4.done}) begin
                n_err++; $display("FAIL restart_d4 c=%0d got %b want %b", c,
                    {nib4, step4, busy4, done4}, {m4.nib, m4.step, m4.busy, m4.done});
            end
            if (c == 0) begin
                n_vec++;
                if ({nib4, step4, busy4} !== {4'h9, 2'b11}) begin
                    n_err++; $display("FAIL restart_first got %b want %b", {nib4, step4, busy4}, {4'h9, 2'b11});
                end
            end
        end
    endtask

    task automatic test_hold_dwell1;
        logic [6:0] want [3] = '{{4'hA, 3'b110}, {4'hA, 3'b001}, {4'hA, 3'b110}};
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            start    = (c < 12);
            mode     = 2'b11;
            load_val = 4'hA;
            @(posedge clk); #1;
            n_vec++;
            if ({nib1, step1, busy1, done1} !== {m1.nib, m1.step, m1.busy, m1.done}) begin
                n_err++; $display("FAIL hold_d1 c=%0d got %b want %b", c,
                    {nib1, step1, busy1, done1}, {m1.nib, m1.step, m1.busy, m1.done});
            end
            n_vec++;
            if ({nib4, step4, busy4, done4} !== {m4.nib, m4.step, m4.busy, m4.done}) begin
                n_err++; $display("FAIL hold_d4 c=%0d got %b want %b", c,
                    {nib4, step4, busy4, done4}, {m4.nib, m4.step, m4.busy, m4.done});
            end
            if (c < 3) begin
                n_vec++;
                if ({nib1, step1, busy1, done1} !== want[c]) begin
                    n_err++; $display("FAIL hold_gap c=%0d got %b want %b", c, {nib1, step1, busy1, done1}, want[c]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run;
        logic hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            start    = (c == 0) ? 1'b1 : 1'($urandom);
            mode     = (c == 0) ? 2'b00 : 2'($urandom);
            load_val = (c == 0) ? 4'h2 : 4'($urandom);
            @(posedge clk); #1;
            n_vec++;
            if ({nib4, step4, busy4, done4} !== {m4.nib, m4.step, m4.busy, m4.done}) begin
                n_err++; $display("FAIL midrun_d4 c=%0d got %b want %b", c,
                    {nib4, step4, busy4, done4}, {m4.nib, m4.step, m4.busy, m4.done});
            end
            hit = m4.run && (m4.nib == 4'h5);
        end
        n_vec++;
        if (!hit) begin
            n_err++; $display("FAIL midrun_reach got nib %h want 5", nib4);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({nib4, step4, busy4, done4, nib1, step1, busy1, done1} !== 14'b0) begin
            n_err++; $display("FAIL midrun_reset got %b want %b",
                {nib4, step4, busy4, done4, nib1, step1, busy1, done1}, 14'b0);
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_random;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 255) == 0);
            start    = ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 31) == 0);
            mode     = 2'($urandom);
            load_val = 4'($urandom);
            @(posedge clk); #1;
            n_vec++;
            if ({nib4, step4, busy4, done4} !== {m4.nib, m4.step, m4.busy, m4.done}) begin
                n_err++; $display("FAIL rand_d4 c=%0d got %b want %b", c,
                    {nib4, step4, busy4, done4}, {m4.nib, m4.step, m4.busy, m4.done});
            end
            n_vec++;
            if ({nib1, step1, busy1, done1} !== {m1.nib, m1.step, m1.busy, m1.done}) begin
                n_err++; $display("FAIL rand_d1 c=%0d got %b want %b", c,
                    {nib1, step1, busy1, done1}, {m1.nib, m1.step, m1.busy, m1.done});
            end
        end
    endtask

    initial begin
        test_reset;
        test_count_modes;
        test_stop;
        test_hold_dwell1;
        test_reset_mid_run;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nibble_seq_gen.md
Name: nibble_seq_gen

Overview:
- Registered 4-bit stimulus sequencer that sits directly upstream of the 4-bit inverter stage and drives its A_in bus.
- Emits a programmable sequence of nibble values, holding each value for a fixed dwell time.
- Replaces hand-timed stimulus with on-chip sequencing, so the inverter can be exercised on the board.
- Start/stop handshake, with BUSY/DONE status and a per-value STEP strobe for downstream capture.

Parameters:
- DWELL, 10, clock cycles each value is held (10 cycles = 100 ns at 100 MHz); legal range 1..65535.
- DW_BITS, 16, width of the internal dwell counter; must satisfy 2^DW_BITS > DWELL.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  level-sampled; begins a sequence when the block is idle.
- STOP  in  1  level-sampled; aborts a running sequence.
- MODE  in  2  sequence select, sampled on the START cycle.
- LOAD_VAL  in  4  start value, sampled on the START cycle.
- NIB_OUT  out  4  registered nibble; connects to the inverter's A_in.
- STEP  out  1  one-cycle pulse, coincident with each new NIB_OUT value.
- BUSY  out  1  high while a sequence is running.
- DONE  out  1  one-cycle pulse when a sequence completes normally.

Behaviour:
- One clock domain; reset is synchronous and active-high, on ports CLK and RST.
- Reset values: NIB_OUT=0, STEP=0, BUSY=0, DONE=0; state=IDLE; dwell counter=0; step count=0.
- States are IDLE and RUN.
- IDLE:
  - NIB_OUT holds its last value.
  - STOP has no effect.
  - START=1 on edge N: MODE is latched; NIB_OUT takes its first value, BUSY=1 and STEP=1 at edge N+1; state becomes RUN.
- First value by MODE:
  - 00 (count up): LOAD_VAL.
  - 01 (count down): LOAD_VAL.
  - 10 (walking one): 4'b0001; LOAD_VAL is ignored.
  - 11 (hold): LOAD_VAL.
- RUN:
  - Dwell counter increments every cycle. When it equals DWELL-1, it clears and the value advances.
  - Each value is therefore visible for exactly DWELL cycles.
  - Advance rules:
    - 00: +1 mod 16 (F wraps to 0).
    - 01: -1 mod 16 (0 wraps to F).
    - 10: rotate left (1000 wraps to 0001).
  - STEP pulses high for one cycle with each new value.
- Sequence length, counting the first value:
  - 00/01: 16 values.
  - 10: 4 values.
  - 11: 1 value.
- Completion: after the final value's dwell expires, the next edge sets state=IDLE, BUSY=0 and pulses DONE for 1 cycle. NIB_OUT keeps the final value and STEP does not pulse.
- STOP in RUN: the next edge sets state=IDLE, BUSY=0, DONE=0 and clears the dwell counter. NIB_OUT holds its current value.
- STOP and dwell expiry on the same cycle: STOP wins, so there is no advance and no STEP.
- START during RUN is ignored; MODE and LOAD_VAL changes during RUN are ignored.
- START held high continuously: a new sequence begins on the first IDLE cycle after DONE, so a gap of one IDLE cycle is required.
- DWELL=1: the value advances every cycle and STEP stays high throughout RUN.
- RST asserted mid-RUN: all outputs return to reset values on the next edge. DONE is not pulsed.
- All outputs are driven directly from flops, with no combinational input-to-output paths.

Decomposition:
- A shared include file holds:
  - MODE encodings: MODE_UP=2'b00, MODE_DN=2'b01, MODE_WALK=2'b10, MODE_HOLD=2'b11.
  - State encodings: ST_IDLE, ST_RUN.
  - Sequence-length constants: 16, 4, 1.
- One sub-module: dwell_timer, a DW_BITS-wide counter with clear/enable inputs and a terminal-count output at DWELL-1.
- The sequencer FSM, step counter and value logic stay in nibble_seq_gen.

Test Plan:
- DWELL=4, MODE=00, LOAD_VAL=E:
  - START pulse → NIB_OUT E,F,0,1,…,D, each held 4 cycles.
  - 16 STEP pulses.
  - DONE pulse 64 cycles after the first value; NIB_OUT stays D.
- DWELL=4, MODE=01, LOAD_VAL=1:
  - NIB_OUT 1,0,F,E,…,2.
  - BUSY high 64 cycles, then a single DONE pulse.
- MODE=10, LOAD_VAL=7:
  - NIB_OUT 1,2,4,8 (LOAD_VAL ignored), 4 STEP pulses, then DONE.
- MODE=00, STOP asserted on the 2nd cycle of value 3:
  - Next edge: BUSY=0, DONE stays 0, NIB_OUT holds 3.
  - Later START restarts from the new LOAD_VAL.
- DWELL=1, MODE=11, LOAD_VAL=A:
  - NIB_OUT=A with STEP and BUSY high 1 cycle, then DONE.
  - START held high → next sequence starts after one IDLE cycle.
- RST during RUN at value 5:
  - NIB_OUT=0, BUSY=0, STEP=0, DONE=0 next edge.
  - START, MODE and LOAD_VAL changes while running have no effect.
